vga_timing_ctrl: RTL and testbench

Parametrised VGA timing and pixel-output controller, the successor to the fixed-width 12-bit VGA controller. It generates programmable h/v counters, sync pulses with selectable polarity, a pixel request to the ping-pong line buffer, and registered RGB output. It adds a frame-synchronous built-in test-pattern generator (colour bars, solid colour, checkerboard), underflow detection, an enable input and a frame-start strobe. It sits between the register block and the VGA pads.

---
 rtl/vga_timing_ctrl_if.sv | 11 +
 rtl/vga_timing_ctrl.sv | 149 ++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_ctrl_if.sv
// Pixel request/data handshake between the VGA timing controller and the line buffer.
interface vga_timing_ctrl_if #(
  parameter int unsigned CDW = 4
);
  logic               data_req_o;
  logic [3*CDW-1:0]   data_i;
  logic               data_vld_i;

  modport master (output data_req_o, input data_i, input data_vld_i);
  modport slave  (input data_req_o, output data_i, output data_vld_i);
endinterface

// File: rtl/vga_timing_ctrl.sv
// Programmable VGA timing generator with registered sync/RGB outputs, a frame-synchronous
// test-pattern generator and sticky line-buffer underflow detection.
module vga_timing_ctrl #(
  parameter int unsigned CW        = 12,
  parameter int unsigned CDW       = 4,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned BAR_SHIFT = 5,
  parameter int unsigned CHK_SHIFT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en_i,
  input  logic [CW-1:0]     hsync_end_i,
  input  logic [CW-1:0]     hpulse_end_i,
  input  logic [CW-1:0]     hdata_begin_i,
  input  logic [CW-1:0]     hdata_end_i,
  input  logic [CW-1:0]     vsync_end_i,
  input  logic [CW-1:0]     vpulse_end_i,
  input  logic [CW-1:0]     vdata_begin_i,
  input  logic [CW-1:0]     vdata_end_i,
  input  logic [1:0]        mode_i,
  input  logic [3*CDW-1:0]  solid_i,
  input  logic              underflow_clr_i,
  vga_timing_ctrl_if.master pix,
  output logic [CDW-1:0]    red_o,
  output logic [CDW-1:0]    green_o,
  output logic [CDW-1:0]    blue_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              blank_o,
  output logic              frame_start_o,
  output logic              underflow_o
);

  localparam int unsigned PW = 3 * CDW;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_BARS   = 2'b01,
    MODE_SOLID  = 2'b10,
    MODE_CHECK  = 2'b11
  } mode_e;

  logic [CW-1:0] hcount, vcount, hcount_nxt, vcount_nxt;
  logic [CW-1:0] x, y;
  mode_e         mode_sh;
  logic [PW-1:0] solid_sh, pix_nxt;
  logic          h_wrap, v_wrap, frame_end, active, underflow_set;
  logic [2:0]    bar_idx, bar_bgr;
  logic          chk_bit;

  // Wrap compares use >= so a live reprogram below the current count recovers next cycle
  assign h_wrap    = hcount >= (hsync_end_i - CW'(1));
  assign v_wrap    = vcount >= (vsync_end_i - CW'(1));
  assign frame_end = en_i && h_wrap && v_wrap;

  assign active = (hcount >= hdata_begin_i) && (hcount < hdata_end_i) &&
                  (vcount >= vdata_begin_i) && (vcount < vdata_end_i);

  assign pix.data_req_o = en_i && active && (mode_sh == MODE_NORMAL);
  assign underflow_set  = pix.data_req_o && !pix.data_vld_i;

  assign x = hcount - hdata_begin_i;
  assign y = vcount - vdata_begin_i;

  // Counter next-state
  always_comb begin
    hcount_nxt = hcount;
    vcount_nxt = vcount;
    if (!en_i) begin
      hcount_nxt = '0;
      vcount_nxt = '0;
    end else if (h_wrap) begin
      hcount_nxt = '0;
      vcount_nxt = v_wrap ? '0 : vcount + CW'(1);
    end else begin
      hcount_nxt = hcount + CW'(1);
    end
  end

  // Pixel source selection; bar colours are {B,G,R} on/off per channel
  always_comb begin
    bar_idx = 3'(x >> BAR_SHIFT);
    chk_bit = 1'((x >> CHK_SHIFT) ^ (y >> CHK_SHIFT));
    case (bar_idx)
      3'd0:    bar_bgr = 3'b111;
      3'd1:    bar_bgr = 3'b011;
      3'd2:    bar_bgr = 3'b110;
      3'd3:    bar_bgr = 3'b010;
      3'd4:    bar_bgr = 3'b101;
      3'd5:    bar_bgr = 3'b001;
      3'd6:    bar_bgr = 3'b100;
      default: bar_bgr = 3'b000;
    endcase
    pix_nxt = '0;
    if (active) begin
      case (mode_sh)
        MODE_NORMAL: if (pix.data_vld_i) pix_nxt = pix.data_i;
        MODE_BARS:   pix_nxt = {{CDW{bar_bgr[2]}}, {CDW{bar_bgr[1]}}, {CDW{bar_bgr[0]}}};
        MODE_SOLID:  pix_nxt = solid_sh;
        default:     pix_nxt = chk_bit ? '0 : '1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hcount        <= '0;
      vcount        <= '0;
      mode_sh       <= MODE_NORMAL;
      solid_sh      <= '0;
      red_o         <= '0;
      green_o       <= '0;
      blue_o        <= '0;
      hsync_o       <= ~HS_POL;
      vsync_o       <= ~VS_POL;
      blank_o       <= 1'b0;
      frame_start_o <= 1'b0;
      underflow_o   <= 1'b0;
    end else begin
      hcount <= hcount_nxt;
      vcount <= vcount_nxt;
      // Shadows only move at the frame boundary to avoid tearing
      if (frame_end) begin
        mode_sh  <= mode_e'(mode_i);
        solid_sh <= solid_i;
      end
      if (!en_i) begin
        red_o         <= '0;
        green_o       <= '0;
        blue_o        <= '0;
        hsync_o       <= ~HS_POL;
        vsync_o       <= ~VS_POL;
        blank_o       <= 1'b0;
        frame_start_o <= 1'b0;
        underflow_o   <= 1'b0;
      end else begin
        {blue_o, green_o, red_o} <= pix_nxt;
        hsync_o       <= (hcount < hpulse_end_i) ? HS_POL : ~HS_POL;
        vsync_o       <= (vcount < vpulse_end_i) ? VS_POL : ~VS_POL;
        blank_o       <= active;
        frame_start_o <= (hcount == '0) && (vcount == '0);
        underflow_o   <= underflow_set || (underflow_o && !underflow_clr_i);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed self-checking bench for vga_timing_ctrl.
module tb_vga_timing_ctrl;

  logic        clk = 1'b0;
  logic        resetn, en;
  logic [11:0] hs_end, hp_end, hd_beg, hd_end, vs_end, vp_end, vd_beg, vd_end;
  logic [1:0]  mode;
  logic [11:0] solid;
  logic        uf_clr;
  logic [3:0]  red, green, blue;
  logic        hsync, vsync, blank, fstart, uflow;
  logic [11:0] rgb;

  int n_assert = 0;
  int n_fail   = 0;
  int kc       = 0;
  int htot     = 1;
  int vtot     = 1;

  vga_timing_ctrl_if #(.CDW(4)) pix_if ();

  vga_timing_ctrl #(.CW(12), .CDW(4), .HS_POL(1'b0), .VS_POL(1'b0),
                    .BAR_SHIFT(5), .CHK_SHIFT(1)) dut (
    .clk(clk), .resetn(resetn), .en_i(en),
    .hsync_end_i(hs_end), .hpulse_end_i(hp_end), .hdata_begin_i(hd_beg), .hdata_end_i(hd_end),
    .vsync_end_i(vs_end), .vpulse_end_i(vp_end), .vdata_begin_i(vd_beg), .vdata_end_i(vd_end),
    .mode_i(mode), .solid_i(solid), .underflow_clr_i(uf_clr), .pix(pix_if),
    .red_o(red), .green_o(green), .blue_o(blue), .hsync_o(hsync), .vsync_o(vsync),
    .blank_o(blank), .frame_start_o(fstart), .underflow_o(uflow)
  );

  assign rgb = {blue, green, red};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    kc++;
  endtask

  // Advance until the DUT counters sit at (h,v), tracked by cycles since enable
  task automatic go_to(input int h, input int v);
    int n;
    n = 0;
    while (!(((kc % htot) == h) && (((kc / htot) % vtot) == v)) && (n < 5000)) begin
      step();
      n++;
    end
  endtask

  task automatic cfg(input int hs, input int hp, input int hb, input int he,
                     input int vs, input int vp, input int vb, input int ve);
    hs_end = 12'(hs); hp_end = 12'(hp); hd_beg = 12'(hb); hd_end = 12'(he);
    vs_end = 12'(vs); vp_end = 12'(vp); vd_beg = 12'(vb); vd_end = 12'(ve);
    htot = hs;
    vtot = vs;
  endtask

  initial begin
    int h, v, cnt_hs, cnt_vs, cnt_req, cnt_fs;
    logic act;
    logic [11:0] pdata;

    resetn = 1'b1; en = 1'b0; mode = 2'b00; solid = '0; uf_clr = 1'b0;
    pix_if.data_i = 12'hABC; pix_if.data_vld_i = 1'b1;
    cfg(10, 2, 3, 7, 6, 1, 2, 4);
    #2 resetn = 1'b0;
    #1;
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_hsync", 32'(hsync), 32'h1);
    chk("rst_vsync", 32'(vsync), 32'h1);
    chk("rst_blank", 32'(blank), 32'h0);
    chk("rst_fstart", 32'(fstart), 32'h0);
    chk("rst_uflow", 32'(uflow), 32'h0);
    chk("rst_req", 32'(pix_if.data_req_o), 32'h0);

    @(posedge clk); #1;
    resetn = 1'b1;
    en = 1'b1;
    kc = 0;

    // Two full frames of small timing with per-pixel data
    cnt_hs = 0; cnt_vs = 0; cnt_req = 0; cnt_fs = 0;
    for (int k = 0; k < 120; k++) begin
      h = k % 10;
      v = (k / 10) % 6;
      act = (h >= 3) && (h < 7) && (v >= 2) && (v < 4);
      pdata = 12'(k * 73 + 5);
      if (k == 23) pdata = 12'hABC;
      pix_if.data_i = pdata;
      chk("req", 32'(pix_if.data_req_o), 32'(act));
      if (pix_if.data_req_o) cnt_req++;
      step();
      chk("blank", 32'(blank), 32'(act));
      chk("rgb", 32'(rgb), act ? 32'(pdata) : 32'h0);
      chk("hsync", 32'(hsync), (h < 2) ? 32'h0 : 32'h1);
      chk("vsync", 32'(vsync), (v < 1) ? 32'h0 : 32'h1);
      chk("fstart", 32'(fstart), (h == 0 && v == 0) ? 32'h1 : 32'h0);
      if (!hsync) cnt_hs++;
      if (!vsync) cnt_vs++;
      if (fstart) cnt_fs++;
      if (k == 23) begin
        chk("red_C", 32'(red), 32'hC);
        chk("green_B", 32'(green), 32'hB);
        chk("blue_A", 32'(blue), 32'hA);
      end
    end
    chk("hsync_low_2frames", 32'(cnt_hs), 32'd24);
    chk("vsync_low_2frames", 32'(cnt_vs), 32'd20);
    chk("req_2frames", 32'(cnt_req), 32'd16);
    chk("fstart_2frames", 32'(cnt_fs), 32'd2);

    // Underflow: set, sticky, clear, coincident set/clear
    pix_if.data_i = 12'hABC;
    go_to(3, 2);
    chk("uf_req", 32'(pix_if.data_req_o), 32'h1);
    pix_if.data_vld_i = 1'b0;
    step();
    pix_if.data_vld_i = 1'b1;
    chk("uf_rgb_zero", 32'(rgb), 32'h0);
    chk("uf_blank", 32'(blank), 32'h1);
    chk("uf_set", 32'(uflow), 32'h1);
    step(); step(); step();
    chk("uf_sticky", 32'(uflow), 32'h1);
    uf_clr = 1'b1;
    step();
    uf_clr = 1'b0;
    chk("uf_clear", 32'(uflow), 32'h0);
    go_to(4, 3);
    pix_if.data_vld_i = 1'b0;
    uf_clr = 1'b1;
    step();
    pix_if.data_vld_i = 1'b1;
    uf_clr = 1'b0;
    chk("uf_set_wins", 32'(uflow), 32'h1);
    uf_clr = 1'b1;
    step();
    uf_clr = 1'b0;
    chk("uf_clear2", 32'(uflow), 32'h0);

    // Mode change mid-frame takes effect only on the next frame
    mode = 2'b01;
    pix_if.data_i = 12'h123;
    chk("mode_hold_req", 32'(pix_if.data_req_o), 32'h1);
    step();
    chk("mode_hold_rgb", 32'(rgb), 32'h123);
    go_to(3, 2);
    chk("bars_no_req", 32'(pix_if.data_req_o), 32'h0);
    step();
    chk("bars_small", 32'(rgb), 32'hFFF);
    chk("bars_small_blank", 32'(blank), 32'h1);

    // Wide timing for colour bars, checkerboard and solid
    en = 1'b0;
    resetn = 1'b0;
    cfg(300, 10, 20, 276, 5, 1, 1, 4);
    mode = 2'b01;
    @(posedge clk); #1;
    resetn = 1'b1;
    en = 1'b1;
    kc = 0;
    go_to(299, 4);
    step();
    go_to(20, 1);
    step();
    chk("bar_col0", 32'(rgb), 32'hFFF);
    go_to(52, 1);
    chk("bar_req_off", 32'(pix_if.data_req_o), 32'h0);
    step();
    chk("bar_col32", 32'(rgb), 32'h0FF);
    go_to(84, 1);
    step();
    chk("bar_col64", 32'(rgb), 32'hFF0);
    go_to(244, 1);
    step();
    chk("bar_col224", 32'(rgb), 32'h000);
    chk("bar_col224_blank", 32'(blank), 32'h1);
    mode = 2'b11;
    go_to(30, 2);
    step();
    chk("bar_midframe_hold", 32'(rgb), 32'hFFF);

    go_to(299, 4);
    step();
    go_to(20, 1);
    step();
    chk("chk_0_0", 32'(rgb), 32'hFFF);
    go_to(21, 2);
    step();
    chk("chk_1_1", 32'(rgb), 32'hFFF);
    go_to(22, 2);
    step();
    chk("chk_2_1", 32'(rgb), 32'h000);
    go_to(22, 3);
    step();
    chk("chk_2_2", 32'(rgb), 32'hFFF);
    mode = 2'b10;
    solid = 12'h5A3;

    go_to(299, 4);
    step();
    go_to(20, 1);
    step();
    chk("solid_first", 32'(rgb), 32'h5A3);
    solid = 12'hFFF;
    go_to(10, 2);
    step();
    chk("solid_outside", 32'(rgb), 32'h000);
    chk("solid_outside_blank", 32'(blank), 32'h0);
    go_to(150, 3);
    step();
    chk("solid_shadow_hold", 32'(rgb), 32'h5A3);
    go_to(100, 2);
    step();
    chk("solid_relatched", 32'(rgb), 32'hFFF);

    // Asynchronous reset mid-line
    #2 resetn = 1'b0;
    #1;
    chk("arst_rgb", 32'(rgb), 32'h0);
    chk("arst_blank", 32'(blank), 32'h0);
    chk("arst_hsync", 32'(hsync), 32'h1);
    chk("arst_vsync", 32'(vsync), 32'h1);
    chk("arst_fstart", 32'(fstart), 32'h0);

    // Enable gating
    @(posedge clk); #1;
    resetn = 1'b1;
    step();
    chk("en_fs_first", 32'(fstart), 32'h1);
    chk("en_hsync_first", 32'(hsync), 32'h0);
    chk("en_vsync_first", 32'(vsync), 32'h0);
    step(); step();
    chk("en_fs_drop", 32'(fstart), 32'h0);
    chk("en_hsync_pulse", 32'(hsync), 32'h0);
    en = 1'b0;
    step();
    chk("dis_hsync", 32'(hsync), 32'h1);
    chk("dis_vsync", 32'(vsync), 32'h1);
    chk("dis_blank", 32'(blank), 32'h0);
    chk("dis_req", 32'(pix_if.data_req_o), 32'h0);
    step(); step(); step(); step();
    chk("dis_hsync_hold", 32'(hsync), 32'h1);
    chk("dis_fstart", 32'(fstart), 32'h0);
    en = 1'b1;
    step();
    chk("reen_fs", 32'(fstart), 32'h1);
    chk("reen_hsync", 32'(hsync), 32'h0);
    chk("reen_vsync", 32'(vsync), 32'h0);
    step();
    chk("reen_fs_once", 32'(fstart), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
